// File: rtl/cpu_controller.sv
// cpu_controller: Moore FSM sequencing register-file and ALU strobes for the
// MOV/ALU instruction subset; all outputs decode from state and the captured IR.
module cpu_controller (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        write,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);
    typedef enum logic [2:0] {WAIT, DECODE, GET_A, GET_B, EXEC, WR_REG, WR_IMM} state_t;
    state_t state, state_next;
    logic [15:0] ir;
    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op, sh;
    logic mov_imm, mov_reg, alu, mvn, cmp;
    assign opcode  = ir[15:13];
    assign op      = ir[12:11];
    assign rn      = ir[10:8];
    assign rd      = ir[7:5];
    assign sh      = ir[4:3];
    assign rm      = ir[2:0];
    assign mov_imm = opcode == 3'b110 && op == 2'b10;
    assign mov_reg = opcode == 3'b110 && op == 2'b00;
    assign alu     = opcode == 3'b101;
    assign mvn     = alu && op == 2'b11;
    assign cmp     = alu && op == 2'b01;
    assign sximm8  = {{8{ir[7]}}, ir[7:0]};
    assign sximm5  = {{11{ir[4]}}, ir[4:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= WAIT;
            ir    <= 16'h0000;
        end else begin
            state <= state_next;
            if (state == WAIT && s) ir <= in;
        end
    end

    always_comb begin
        state_next = WAIT;
        w        = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        vsel     = 2'b00;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        write    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        shift    = 2'b00;
        ALUop    = 2'b00;
        case (state)
            WAIT: begin
                w          = 1'b1;
                state_next = s ? DECODE : WAIT;
            end
            DECODE: state_next = mov_imm ? WR_IMM : (mov_reg || mvn) ? GET_B : alu ? GET_A : WAIT;
            GET_A: begin
                readnum    = rn;
                loada      = 1'b1;
                state_next = GET_B;
            end
            GET_B: begin
                readnum    = rm;
                loadb      = 1'b1;
                state_next = EXEC;
            end
            EXEC: begin
                // MOV reg passes Rm through as 0 + Rm; every ALU opcode uses op directly
                shift      = sh;
                asel       = mov_reg || mvn;
                ALUop      = mov_reg ? 2'b00 : op;
                loads      = cmp;
                loadc      = !cmp;
                state_next = cmp ? WAIT : WR_REG;
            end
            WR_REG: begin
                writenum = rd;
                write    = 1'b1;
            end
            WR_IMM: begin
                writenum = rn;
                vsel     = 2'b10;
                write    = 1'b1;
            end
            default: state_next = WAIT;
        endcase
    end
endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: scoreboard bench; stimulus pushes per-cycle expected output
// vectors derived from instruction semantics, a monitor pops and compares each cycle.
module tb_cpu_controller;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        s = 1'b0;
    logic [15:0] in = 16'h0000;
    logic        w, loada, loadb, loadc, loads, write, asel, bsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel, shift, ALUop;
    logic [15:0] sximm8, sximm5;
    logic [51:0] dut_vec;
    logic [51:0] q[$];
    logic [15:0] model_ir = 16'h0000;
    bit          cur_idle = 1'b1;
    int          tests = 0;
    int          fails = 0;

    cpu_controller dut (
        .clk(clk), .reset_n(reset_n), .s(s), .in(in), .w(w),
        .readnum(readnum), .writenum(writenum), .vsel(vsel),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .write(write),
        .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
        .sximm8(sximm8), .sximm5(sximm5)
    );

    always #5 clk = ~clk;

    assign dut_vec = {w, readnum, writenum, vsel, loada, loadb, loadc, loads, write,
                      asel, bsel, shift, ALUop, sximm8, sximm5};

    function automatic logic [15:0] sext(input int v, input int bits);
        int r;
        r = (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
        return r[15:0];
    endfunction

    function automatic logic [51:0] mk(input logic wv, input logic [2:0] rn_, input logic [2:0] wn_,
                                       input logic [1:0] vs, input logic la, input logic lb,
                                       input logic lc, input logic ls, input logic wr,
                                       input logic as, input logic [1:0] sh_, input logic [1:0] alu_,
                                       input logic [15:0] ir_);
        return {wv, rn_, wn_, vs, la, lb, lc, ls, wr, as, 1'b0, sh_, alu_,
                sext(int'(ir_[7:0]), 8), sext(int'(ir_[4:0]), 5)};
    endfunction

    function automatic logic [51:0] idle(input logic [15:0] ir_);
        return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ir_);
    endfunction

    task automatic check(input string name, input logic [51:0] act, input logic [51:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Expected non-WAIT cycles of one instruction, in order.
    task automatic issue(input logic [15:0] i);
        logic [2:0] opc, rn, rd, rm;
        logic [1:0] op, sh;
        bit alu_class, mov_r, mov_i, is_cmp, is_mvn;
        opc = i[15:13]; op = i[12:11]; rn = i[10:8]; rd = i[7:5]; sh = i[4:3]; rm = i[2:0];
        alu_class = opc == 3'd5;
        mov_r = opc == 3'd6 && op == 2'd0;
        mov_i = opc == 3'd6 && op == 2'd2;
        is_cmp = alu_class && op == 2'd1;
        is_mvn = alu_class && op == 2'd3;
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, i));
        if (mov_i)
            q.push_back(mk(0, 0, rn, 2'b10, 0, 0, 0, 0, 1, 0, 0, 0, i));
        else if (mov_r || alu_class) begin
            if (alu_class && !is_mvn) q.push_back(mk(0, rn, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, i));
            q.push_back(mk(0, rm, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, i));
            if (is_cmp)
                q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, sh, 2'b01, i));
            else begin
                q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, mov_r || is_mvn, sh, mov_r ? 2'b00 : op, i));
                q.push_back(mk(0, 0, rd, 0, 0, 0, 0, 0, 1, 0, 0, 0, i));
            end
        end
        model_ir = i;
    endtask

    task automatic drive_now(input logic sv, input logic [15:0] iv);
        s = sv;
        in = iv;
        if (cur_idle && q.size() == 0 && sv) issue(iv);
    endtask

    task automatic drive(input logic sv, input logic [15:0] iv);
        @(negedge clk);
        drive_now(sv, iv);
    endtask

    initial begin
        forever begin
            logic [51:0] exp;
            @(posedge clk);
            #1;
            if (reset_n) begin
                if (q.size() != 0) begin
                    exp = q.pop_front();
                    cur_idle = 1'b0;
                end else begin
                    exp = idle(model_ir);
                    cur_idle = 1'b1;
                end
                check("cycle", dut_vec, exp);
            end
        end
    end

    initial begin
        logic [15:0] r;
        #3;
        check("reset_idle", dut_vec, idle(16'h0000));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        drive_now(1, 16'hD0FD);
        drive(0, 16'h0000);
        repeat (3) drive(0, 16'hFFFF);
        drive(1, 16'hA148);
        repeat (6) drive(0, 16'h0000);
        drive(1, 16'hA902);
        repeat (5) drive(0, 16'h0000);
        drive(1, 16'hC075);
        repeat (5) drive(0, 16'h0000);
        drive(1, 16'h0000);
        drive(1, 16'hD7AA);
        drive(0, 16'h1234);
        drive(1, 16'hC875);
        repeat (5) drive(0, 16'h0000);
        drive(1, 16'hA148);
        repeat (3) drive(0, 16'h0000);
        #2 reset_n = 1'b0;
        #1 check("async_reset", dut_vec, idle(16'h0000));
        q.delete();
        cur_idle = 1'b1;
        model_ir = 16'h0000;
        @(negedge clk);
        check("reset_hold", dut_vec, idle(16'h0000));
        reset_n = 1'b1;
        drive_now(1, 16'hB8E1);
        repeat (5) drive(1, 16'hB8E1);
        for (int k = 0; k < 600; k++) begin
            r = 16'($urandom);
            if ($urandom_range(0, 3) != 0) r[15:13] = $urandom_range(0, 1) ? 3'b101 : 3'b110;
            drive(1'($urandom_range(0, 1)), r);
        end
        repeat (8) drive(0, 16'h0000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
